alu_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered ALU between two requesters, e.g. the CPU execute path (port 0) and an auxiliary unit (port 1). It accepts one operation at a time through a req/ack handshake, latches operands, and executes ADD, SUB, MOV_A or MOV_B in the following cycle. It returns the result and NZCV flags with a one-cycle valid pulse to the owning requester. The op encoding matches the ALU definitions: result select 2'b10/2'b11 and arithmetic 1'b0 = add, 1'b1 = sub.

---
 rtl/alu_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one registered ALU (ADD, SUB, MOV_A, MOV_B with NZCV flags)
//   between two requesters using a round-robin req/ack handshake.
//   A grant in IDLE latches the winner's operands and pulses its ack.
//   The following cycle (EXEC) registers the result and flags and pulses
//   the owner's rsp_valid.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   req0/req1               request, held high until ack
//   op0/op1   [1:0]         00 ADD, 01 SUB, 10 MOV_A, 11 MOV_B
//   a0,b0 / a1,b1 [WIDTH]   operands, stable while req is high
//   ack0/ack1               one-cycle pulse: request accepted
//   rsp_valid0/rsp_valid1   one-cycle pulse: rsp_result/rsp_flags valid
//   rsp_result [WIDTH]      shared result register, held between ops
//   rsp_flags  [3:0]        {N, Z, C, V}, held between ops
//   busy                    high while the FSM is in EXEC
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state_q;
  logic               owner_q;
  logic               prio_q;
  logic [1:0]         ack_q;
  logic [1:0]         rsp_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic [3:0]         rsp_flags_q;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic               grant;
  logic               win;
  logic [1:0]         op_d;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   b_d;
  logic [WIDTH+3:0]   alu_out;
  logic [WIDTH-1:0]   rsp_result_d;
  logic [3:0]         rsp_flags_d;

  // Returns {N, Z, C, V, result}. op[1] selects a move, op[0] picks
  // subtract (or MOV_B). Subtract is A + ~B + 1, so C = 1 means no borrow.
  function automatic logic [WIDTH+3:0] alu_eval(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    bx  = op[0] ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, op[0]};
    if (op[1]) begin
      r = op[0] ? b : a;
      c = 1'b0;
      v = 1'b0;
    end else begin
      r = sum[WIDTH-1:0];
      c = sum[WIDTH];
      // Overflow: operands' signs (B inverted for subtract) agree but the
      // result's sign differs from A.
      v = (a[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return {r[WIDTH-1], (r == '0), c, v, r};
  endfunction

  // Winner selection: a lone requester wins; on contention prio decides.
  always_comb begin
    grant = req0 | req1;
    win   = (req0 & req1) ? prio_q : req1;
    op_d  = win ? op1 : op0;
    a_d   = win ? a1  : a0;
    b_d   = win ? b1  : b0;
  end

  always_comb begin
    alu_out      = alu_eval(op_q, a_q, b_q);
    rsp_result_d = alu_out[WIDTH-1:0];
    rsp_flags_d  = alu_out[WIDTH+3:WIDTH];
  end

  // Operand latch: only ever read in EXEC after a grant, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && grant) begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      prio_q       <= 1'b0;
      ack_q        <= 2'b00;
      rsp_valid_q  <= 2'b00;
      busy_q       <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      ack_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q <= win;
            ack_q   <= win ? 2'b10 : 2'b01;
            prio_q  <= ~win;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= rsp_result_d;
          rsp_flags_q  <= rsp_flags_d;
          rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0       = ack_q[0];
  assign ack1       = ack_q[1];
  assign rsp_valid0 = rsp_valid_q[0];
  assign rsp_valid1 = rsp_valid_q[1];
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = busy_q;

endmodule
